// File: rtl/aes_pkg.sv
// Shared AES state-layout constants and byte-index helpers for the round pipeline stages.
// Column-major layout: byte k is row k%4 and column k/4, held at bits [k*8 +: 8] of a [0:127] vector.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_NB    = 4;

  function automatic int idx(input int row, input int col);
    return row + AES_NB * col;
  endfunction

  // Source byte for forward ShiftRows; the inverse stage uses 13*(k%4) in place of 5*(k%4).
  function automatic int shift_src(input int k);
    return (4 * (k / 4) + 5 * (k % 4)) % 16;
  endfunction

endpackage

// File: rtl/shift_rows_stage_if.sv
// Block stream bus for the ShiftRows stage: input side (in/in_tag/in_ready, in_stall back) and output side.
// The slave modport is the stage's view; the master modport is the view of the surrounding producer/consumer.
interface shift_rows_stage_if
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
);

  logic [0:AES_BLK_W-1] in;
  logic [TAG_W-1:0]     in_tag;
  logic                 in_ready;
  logic                 in_stall;
  logic [0:AES_BLK_W-1] out;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_ready;
  logic                 out_stall;

  modport slave (
    input  in, in_tag, in_ready, out_stall,
    output in_stall, out, out_tag, out_ready
  );

  modport master (
    output in, in_tag, in_ready, out_stall,
    input  in_stall, out, out_tag, out_ready
  );

endinterface

// File: rtl/shift_rows_comb.sv
// Forward AES ShiftRows as a pure byte permutation; row i rotates left by i columns.
// Purely combinational, zero latency, no flow control.
module shift_rows_comb
  import aes_pkg::*;
(
  input  logic [0:AES_BLK_W-1] blk,
  output logic [0:AES_BLK_W-1] shifted
);

  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int SRC = shift_src(k);
    assign shifted[k*8 +: 8] = blk[SRC*8 +: 8];
  end

endmodule

// File: rtl/shift_rows_stage.sv
// Registered ShiftRows stage with tag sideband and 2-entry skid buffer; 1-cycle latency, 1 block/cycle.
// in_stall is a flop output (high only when both entries are full); SHIFT_ROWS_COUNT_EN adds blk_count.
module shift_rows_stage
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
)
(
  input  logic              clk,
  input  logic              reset,
  shift_rows_stage_if.slave bus
`ifdef SHIFT_ROWS_COUNT_EN
  ,
  output logic [31:0]       blk_count
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]           st_q;
  logic [0:AES_BLK_W-1] shifted;
  logic [0:AES_BLK_W-1] main_q;
  logic [0:AES_BLK_W-1] skid_q;
  logic [TAG_W-1:0]     main_tag_q;
  logic [TAG_W-1:0]     skid_tag_q;
  logic                 in_xfer;
  logic                 out_xfer;

  shift_rows_comb u_comb (
    .blk     (bus.in),
    .shifted (shifted)
  );

  assign bus.in_stall  = (st_q == TWO);
  assign bus.out_ready = (st_q != EMPTY);
  assign bus.out       = main_q;
  assign bus.out_tag   = main_tag_q;

  assign in_xfer  = bus.in_ready  & ~bus.in_stall;
  assign out_xfer = bus.out_ready & ~bus.out_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= EMPTY;
      main_q     <= '0;
      main_tag_q <= '0;
      skid_q     <= '0;
      skid_tag_q <= '0;
    end else begin
      case (st_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q     <= shifted;
            main_tag_q <= bus.in_tag;
            st_q       <= ONE;
          end
        end
        ONE: begin
          // A stalled output with a new arrival parks the arrival in the skid entry.
          if (in_xfer && bus.out_stall) begin
            skid_q     <= shifted;
            skid_tag_q <= bus.in_tag;
            st_q       <= TWO;
          end else if (in_xfer) begin
            main_q     <= shifted;
            main_tag_q <= bus.in_tag;
          end else if (out_xfer) begin
            st_q <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            main_tag_q <= skid_tag_q;
            st_q       <= ONE;
          end
        end
        default: st_q <= EMPTY;
      endcase
    end
  end

`ifdef SHIFT_ROWS_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign blk_count = cnt_q;
`endif

endmodule
